// File: rtl/ahb2apb_bridge.sv
// AHB slave that turns each accepted AHB beat into one APB3 SETUP+ACCESS sequence.
// Optional: define BRIDGE_ERR_RESP_EN to return PSLVERR/timeout as a two-cycle AHB ERROR.
module ahb2apb_bridge #(
  parameter int unsigned P_ADDR_WIDTH = 16,
  parameter int unsigned P_TIMEOUT    = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADYin,
  output logic                    HREADYout,
  output logic [1:0]              HRESP,
  output logic [31:0]             HRDATA,
  output logic [P_ADDR_WIDTH-1:0] PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned CntW    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(P_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(P_TIMEOUT - 1);
  localparam bit              TmoEn   = (P_TIMEOUT != 0);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSetup,
    StAccess,
`ifdef BRIDGE_ERR_RESP_EN
    StDone,
    StErr1,
    StErr2
`else
    StDone
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    hready_q, hready_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic [P_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [2:0]              hsize_q, hsize_d;
  logic                    accept;
  logic                    tmo;

  assign accept = HSEL & HTRANS[1] & HREADYin;
  assign tmo    = TmoEn && (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hsize_d  = hsize_q;
    unique case (state_q)
`ifdef BRIDGE_ERR_RESP_EN
      StIdle, StDone, StErr2: begin
`else
      StIdle, StDone: begin
`endif
        if (accept) begin
          state_d  = StLatch;
          paddr_d  = HADDR[P_ADDR_WIDTH-1:0];
          pwrite_d = HWRITE;
          hsize_d  = HSIZE;
        end else begin
          state_d = StIdle;
        end
      end
      StLatch: begin
        // HWDATA is only valid in the data phase, one cycle after the address.
        if (pwrite_q) pwdata_d = HWDATA;
        state_d = StSetup;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (PREADY) begin
          if (!pwrite_q) hrdata_d = PRDATA;
`ifdef BRIDGE_ERR_RESP_EN
          state_d = PSLVERR ? StErr1 : StDone;
`else
          state_d = StDone;
`endif
        end else if (tmo) begin
          if (!pwrite_q) hrdata_d = '0;
`ifdef BRIDGE_ERR_RESP_EN
          state_d = StErr1;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BRIDGE_ERR_RESP_EN
      StErr1: state_d = StErr2;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    hready_d  = (state_d == StIdle) || (state_d == StDone);
    psel_d    = (state_d == StSetup) || (state_d == StAccess);
    penable_d = (state_d == StAccess);
`ifdef BRIDGE_ERR_RESP_EN
    if (state_d == StErr2) hready_d = 1'b1;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hready_q  <= 1'b1;
      hrdata_q  <= '0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hsize_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hready_q  <= hready_d;
      hrdata_q  <= hrdata_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hsize_q   <= hsize_d;
    end
  end

`ifdef BRIDGE_ERR_RESP_EN
  logic [1:0] hresp_q, hresp_d;

  always_comb begin
    hresp_d = ((state_d == StErr1) || (state_d == StErr2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hresp_q <= 2'b00;
    else          hresp_q <= hresp_d;
  end

  assign HRESP = hresp_q;
`else
  logic unused_pslverr;
  assign unused_pslverr = PSLVERR;
  assign HRESP = 2'b00;
`endif

  logic unused_bits;
  assign unused_bits = ^{hsize_q, HBURST, HADDR[31:P_ADDR_WIDTH]};

  assign HREADYout = hready_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
